pll_bringup_seq: RTL and testbench

PLL_BRINGUP_SEQ -- requirements
Module: pll_bringup_seq

---
 rtl/pll_seq_pkg.sv | 28 ++
 rtl/pll_trim_ramp.sv | 63 ++++++
 rtl/pll_bringup_seq.sv | 139 +++++++++++++
 tb/tb_pll_bringup_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types, widths and helpers for the PLL bring-up sequencer.
// Imported by pll_trim_ramp and pll_bringup_seq.
package pll_seq_pkg;

  localparam int TRIM_W   = 26;
  localparam int DIV_W    = 5;
  localparam int TRIM_MAX = 26;

  typedef enum logic [2:0] {
    IDLE,
    RST_HOLD,
    SETTLE,
    RAMP,
    RUN,
    SHUTDOWN
  } seq_state_e;

  function automatic logic [TRIM_W-1:0] to_therm(
    input logic [4:0] n
  );
    logic [TRIM_W-1:0] t;
    t = '0;
    for (int i = 0; i < TRIM_W; i++)
      t[i] = (i < int'(n));
    return t;
  endfunction

endpackage

// File: rtl/pll_trim_ramp.sv
// Trim count, step prescaler and thermometer output for the PLL trim.
// PLL_SEQ_RAMP_EN selects stepped ramping; otherwise the count jumps.
module pll_trim_ramp
  import pll_seq_pkg::*;
`ifdef PLL_SEQ_RAMP_EN
#(
  parameter int unsigned RAMP_DIV = 4
)
`endif
(
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        target,
  input  logic              go,
  input  logic              step_en,
  input  logic              clear,
  output logic [TRIM_W-1:0] ext_trim,
  output logic              at_target
);

  logic [4:0] count;

  assign ext_trim = to_therm(count);

`ifdef PLL_SEQ_RAMP_EN
  logic [7:0] pre;
  logic [7:0] pre_cur;
  logic       tick;

  // go marks the first cycle of a ramp, so the prescaler starts at 0
  assign pre_cur   = go ? 8'd0 : pre;
  assign tick      = step_en && (pre_cur == 8'(RAMP_DIV - 1));
  assign at_target = (count == target);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
      pre   <= '0;
    end else if (step_en) begin
      pre <= tick ? 8'd0 : pre_cur + 8'd1;
      if (tick && !at_target) begin
        if (count < target) begin
          if (count != 5'(TRIM_MAX))
            count <= count + 5'd1;
        end else if (count != 5'd0) begin
          count <= count - 5'd1;
        end
      end
    end
  end
`else
  assign at_target = go && step_en;

  always_ff @(posedge clock) begin
    if (reset || clear)
      count <= '0;
    else if (go && step_en)
      count <= (target > 5'(TRIM_MAX)) ?
               5'(TRIM_MAX) : target;
  end
`endif

endmodule

// File: rtl/pll_bringup_seq.sv
// PLL bring-up sequencer: reset hold, settle, trim ramp, run, shutdown.
// Define PLL_SEQ_RAMP_EN for stepped trim ramping at RAMP_DIV.
module pll_bringup_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 256
`ifdef PLL_SEQ_RAMP_EN
  ,
  parameter int unsigned RAMP_DIV      = 4
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_dco,
  input  logic [4:0]        cfg_trim,
  input  logic              stop,
  output logic              pll_enable,
  output logic              pll_resetb,
  output logic              pll_dco,
  output logic [DIV_W-1:0]  pll_div,
  output logic [TRIM_W-1:0] pll_ext_trim,
  output logic              busy,
  output logic              settled,
  output logic              cfg_err
);

  seq_state_e  state;
  logic [15:0] cnt;
  logic [4:0]  tgt;
  logic        entry;
  logic        at_target;
  logic        accept;
  logic        take;
  logic        trim_bad;
  logic        step_en;
  logic        clear;

  assign cfg_ready = (state == IDLE || state == RUN) && !stop;
  assign accept    = cfg_valid && cfg_ready;
  assign trim_bad  = cfg_trim > 5'(TRIM_MAX);
  assign take      = accept && !trim_bad;
  assign busy      = !(state == IDLE || state == RUN);
  assign settled   = (state == RUN);
  assign step_en   = (state == RAMP || state == SHUTDOWN);
  assign clear     = (state == RST_HOLD);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      tgt        <= '0;
      entry      <= 1'b0;
      pll_enable <= 1'b0;
      pll_resetb <= 1'b0;
      pll_dco    <= 1'b0;
      pll_div    <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= accept && trim_bad;
      entry   <= 1'b0;
      // an active shutdown is already heading to IDLE
      if (stop && !(state inside {IDLE, SHUTDOWN})) begin
        state <= SHUTDOWN;
        tgt   <= '0;
        entry <= 1'b1;
      end else begin
        unique case (state)
          IDLE: if (take) begin
            pll_div    <= cfg_div;
            pll_dco    <= cfg_dco;
            tgt        <= cfg_trim;
            pll_enable <= 1'b1;
            pll_resetb <= 1'b0;
            cnt        <= '0;
            state      <= RST_HOLD;
          end
          RST_HOLD:
            if (cnt == 16'(RESET_CYCLES - 1)) begin
              pll_resetb <= 1'b1;
              cnt        <= '0;
              state      <= SETTLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          SETTLE:
            if (cnt == 16'(SETTLE_CYCLES - 1)) begin
              cnt   <= '0;
              entry <= 1'b1;
              state <= RAMP;
            end else begin
              cnt <= cnt + 16'd1;
            end
          RAMP: if (at_target) state <= RUN;
          RUN: if (take) begin
            if (cfg_div != pll_div ||
                cfg_dco != pll_dco) begin
              pll_div    <= cfg_div;
              pll_dco    <= cfg_dco;
              tgt        <= cfg_trim;
              pll_resetb <= 1'b0;
              cnt        <= '0;
              state      <= RST_HOLD;
            end else if (cfg_trim != tgt) begin
              tgt   <= cfg_trim;
              entry <= 1'b1;
              state <= RAMP;
            end
          end
          SHUTDOWN: if (at_target) begin
            pll_enable <= 1'b0;
            pll_resetb <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  pll_trim_ramp
`ifdef PLL_SEQ_RAMP_EN
    #(.RAMP_DIV(RAMP_DIV))
`endif
    u_ramp (
      .clock     (clock),
      .reset     (reset),
      .target    (tgt),
      .go        (entry),
      .step_en   (step_en),
      .clear     (clear),
      .ext_trim  (pll_ext_trim),
      .at_target (at_target)
    );

endmodule

// File: tb/tb_pll_bringup_seq.sv
// Self-checking bench for pll_bringup_seq, scoreboard on settled.
// Timing expectations follow PLL_SEQ_RAMP_EN when it is defined.
module tb_pll_bringup_seq;

  localparam int RD =
`ifdef PLL_SEQ_RAMP_EN
    4;
`else
    0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [4:0]  cfg_div = '0;
  logic        cfg_dco = 1'b0;
  logic [4:0]  cfg_trim = '0;
  logic        stop = 1'b0;
  logic        pll_enable;
  logic        pll_resetb;
  logic        pll_dco;
  logic [4:0]  pll_div;
  logic [25:0] pll_ext_trim;
  logic        busy;
  logic        settled;
  logic        cfg_err;

  always #5 clock = ~clock;

  pll_bringup_seq dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div      (cfg_div),
    .cfg_dco      (cfg_dco),
    .cfg_trim     (cfg_trim),
    .stop         (stop),
    .pll_enable   (pll_enable),
    .pll_resetb   (pll_resetb),
    .pll_dco      (pll_dco),
    .pll_div      (pll_div),
    .pll_ext_trim (pll_ext_trim),
    .busy         (busy),
    .settled      (settled),
    .cfg_err      (cfg_err)
  );

  typedef struct {
    logic [4:0]  div;
    logic        dco;
    logic [25:0] trim;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  logic settled_q = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] th(input int n);
    return 26'((64'd1 << n) - 64'd1);
  endfunction

  function automatic int rc(input int d);
    return (RD > 0) ? RD * d : 1;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_en"}, pll_enable, 0);
    chk({tag, "_rstb"}, pll_resetb, 0);
    chk({tag, "_dco"}, pll_dco, 0);
    chk({tag, "_div"}, pll_div, 0);
    chk({tag, "_trim"}, pll_ext_trim, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_settled"}, settled, 0);
    chk({tag, "_err"}, cfg_err, 0);
    chk({tag, "_ready"}, cfg_ready, 1);
  endtask

  // drive at a negedge, accepted at the next posedge
  task automatic send(input string tag,
                      input logic [4:0] d,
                      input logic m,
                      input logic [4:0] t);
    cfg_div   = d;
    cfg_dco   = m;
    cfg_trim  = t;
    cfg_valid = 1'b1;
    #1;
    chk({tag, "_ready"}, cfg_ready, 1);
    @(negedge clock);
    cfg_valid = 1'b0;
  endtask

  task automatic bringup(input string tag, input int n,
                         input int d, input int c0);
    int c;
    c = c0;
    while (!pll_resetb && c < 100) begin
      @(negedge clock);
      c++;
    end
    chk({tag, "_rst_cyc"}, c - 1, 16);
    chk({tag, "_en"}, pll_enable, 1);
    c = 0;
    while (pll_ext_trim != th(n) && c < 2000) begin
      @(negedge clock);
      c++;
    end
    chk({tag, "_trim_cyc"}, c, 256 + rc(d));
    c = 0;
    while (!settled && c < 10) begin
      @(negedge clock);
      c++;
    end
    chk({tag, "_lag"}, c, (RD > 0) ? 1 : 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  always @(negedge clock) begin
    if (settled && !settled_q) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_div", pll_div, e.div);
        chk("sb_dco", pll_dco, e.dco);
        chk("sb_trim", pll_ext_trim, e.trim);
      end
    end
    settled_q <= settled;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  initial begin
    int  c;
    logic seen;
    repeat (3) @(negedge clock);
    chk_reset("rst");
    reset = 1'b0;

    stop = 1'b1;
    #1;
    chk("stop_idle_ready", cfg_ready, 0);
    @(negedge clock);
    stop = 1'b0;
    chk("stop_idle_busy", busy, 0);
    chk("stop_idle_en", pll_enable, 0);

    sb.push_back('{5'd8, 1'b1, th(10)});
    send("up", 5'd8, 1'b1, 5'd10);
    chk("up_busy", busy, 1);
    chk("up_rstb", pll_resetb, 0);
    bringup("up", 10, 10, 1);

    sb.push_back('{5'd8, 1'b1, th(4)});
    send("tr", 5'd8, 1'b1, 5'd4);
    c = 1;
    seen = 1'b0;
    while (pll_ext_trim != th(4) && c < 500) begin
      if (!pll_resetb || !pll_enable) seen = 1'b1;
      @(negedge clock);
      c++;
    end
    chk("tr_cyc", c - 1, rc(6));
    chk("tr_norst", seen, 0);
    c = 0;
    while (!settled && c < 10) begin
      @(negedge clock);
      c++;
    end
    chk("tr_lag", c, (RD > 0) ? 1 : 0);

    sb.push_back('{5'd12, 1'b1, th(4)});
    send("dv", 5'd12, 1'b1, 5'd4);
    chk("dv_rstb", pll_resetb, 0);
    @(negedge clock);
    chk("dv_clr", pll_ext_trim, 0);
    bringup("dv", 4, 4, 2);
    chk("dv_div", pll_div, 12);

    send("bad", 5'd12, 1'b1, 5'd27);
    chk("bad_err", cfg_err, 1);
    chk("bad_trim", pll_ext_trim, th(4));
    chk("bad_settled", settled, 1);
    @(negedge clock);
    chk("bad_err_end", cfg_err, 0);
    chk("bad_div", pll_div, 12);
    chk("bad_busy", busy, 0);

    send("same", 5'd12, 1'b1, 5'd4);
    chk("same_busy", busy, 0);
    @(negedge clock);
    chk("same_settled", settled, 1);

    send("sd", 5'd12, 1'b1, 5'd20);
    stop      = 1'b1;
    cfg_valid = 1'b1;
    cfg_div   = 5'd3;
    cfg_dco   = 1'b0;
    cfg_trim  = 5'd5;
    #1;
    chk("sd_ready", cfg_ready, 0);
    @(negedge clock);
    stop      = 1'b0;
    cfg_valid = 1'b0;
    c = 2;
    while (pll_enable && c < 500) begin
      @(negedge clock);
      c++;
    end
    chk("sd_cyc", c, (RD > 0) ? 3 + RD * 4 : 3);
    chk("sd_trim", pll_ext_trim, 0);
    chk("sd_rstb", pll_resetb, 0);
    chk("sd_busy", busy, 0);
    chk("sd_settled", settled, 0);
    chk("sd_ready_idle", cfg_ready, 1);
    chk("sd_div", pll_div, 12);
    chk("sd_dco", pll_dco, 1);

    send("mr", 5'd8, 1'b1, 5'd10);
    c = 1;
    while (!pll_resetb && c < 100) begin
      @(negedge clock);
      c++;
    end
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_reset("mr");
    reset = 1'b0;

    sb.push_back('{5'd8, 1'b1, th(10)});
    send("r2", 5'd8, 1'b1, 5'd10);
    bringup("r2", 10, 10, 1);

    repeat (2) @(negedge clock);
    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
